// File: rtl/vram_console_writer_pkg.sv
// Shared types and constants for the text-console video RAM writer.
package vram_console_writer_pkg;

    // Video RAM address width
    localparam int unsigned ADDR_W = 11;

    // Default console geometry and blank character
    localparam int unsigned COLS_DEF = 80;
    localparam int unsigned ROWS_DEF = 25;
    localparam logic [7:0]  FILL_DEF = 8'h20;

    // Control codes
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [2:0] {
        StIdle,
        StPut,
        StScroll,
        StClrLine,
        StClrAll
    } state_t;

endpackage

// File: rtl/vram_console_writer_addr_calc.sv
// Linear cursor address: row*COLS + col, built from shifted copies of row.
module vram_addr_calc
    import vram_console_writer_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEF
) (
    input  logic [4:0]        row,
    input  logic [6:0]        col,
    output logic [ADDR_W-1:0] addr
);

    // Shift-add multiply by the constant COLS; unused terms fold away
    always_comb begin
        addr = ADDR_W'(col);
        for (int i = 0; i < ADDR_W; i++) begin
            if (COLS[i]) begin
                addr = addr + (ADDR_W'(row) << i);
            end
        end
    end

endmodule

// File: rtl/vram_console_writer.sv
// Character stream to text-mode video RAM writer with cursor, scroll and clear.
module vram_console_writer
    import vram_console_writer_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEF,
    parameter int unsigned ROWS = ROWS_DEF,
    parameter logic [7:0]  FILL = FILL_DEF
) (
    input  logic              clk_pxl,
    input  logic              rst,
    input  logic              ch_valid,
    input  logic [7:0]        ch_data,
    output logic              ch_ready,
    output logic              wr_ram_en,
    output logic [ADDR_W-1:0] wr_ram_a,
    output logic [7:0]        wr_ram_do,
    output logic [ADDR_W-1:0] rd_ram_a,
    input  logic [7:0]        rd_ram_di,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] SCROLL_WORDS = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] TOTAL_WORDS  = ADDR_W'(ROWS * COLS);
    localparam logic [ADDR_W-1:0] COLS_A       = ADDR_W'(COLS);
    localparam logic [6:0]        LAST_COL     = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW     = 5'(ROWS - 1);

    state_t              state_q, state_d;
    logic [6:0]          col_q, col_d;
    logic [4:0]          row_q, row_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [7:0]          ch_q, ch_d;
    logic [ADDR_W-1:0]   cur_addr;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_a;
    logic [7:0]          wr_do;
    logic [ADDR_W-1:0]   rd_a;

    vram_addr_calc #(
        .COLS (COLS)
    ) u_addr_calc (
        .row  (row_q),
        .col  (col_q),
        .addr (cur_addr)
    );

    // Next-state, cursor update and RAM port control
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        wr_en   = 1'b0;
        wr_a    = '0;
        wr_do   = '0;
        rd_a    = '0;

        unique case (state_q)
            StIdle: begin
                if (ch_valid) begin
                    case (ch_data)
                        CH_CR: col_d = '0;
                        CH_LF: begin
                            if (row_q < LAST_ROW) begin
                                row_d = row_q + 5'd1;
                            end else begin
                                state_d = StScroll;
                                cnt_d   = '0;
                            end
                        end
                        CH_BS: begin
                            if (col_q != '0) col_d = col_q - 7'd1;
                        end
                        CH_FF: begin
                            state_d = StClrAll;
                            cnt_d   = '0;
                        end
                        default: begin
                            ch_d    = ch_data;
                            state_d = StPut;
                        end
                    endcase
                end
            end

            StPut: begin
                wr_en = 1'b1;
                wr_a  = cur_addr;
                wr_do = ch_q;
                if (col_q < LAST_COL) begin
                    col_d   = col_q + 7'd1;
                    state_d = StIdle;
                end else begin
                    col_d = '0;
                    if (row_q < LAST_ROW) begin
                        row_d   = row_q + 5'd1;
                        state_d = StIdle;
                    end else begin
                        state_d = StScroll;
                        cnt_d   = '0;
                    end
                end
            end

            // cnt is the read index; the write trails it by one cycle
            StScroll: begin
                if (cnt_q < SCROLL_WORDS) rd_a = cnt_q + COLS_A;
                if (cnt_q != '0) begin
                    wr_en = 1'b1;
                    wr_a  = cnt_q - ADDR_W'(1);
                    wr_do = rd_ram_di;
                end
                if (cnt_q == SCROLL_WORDS) begin
                    state_d = StClrLine;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end

            StClrLine: begin
                wr_en = 1'b1;
                wr_a  = SCROLL_WORDS + cnt_q;
                wr_do = FILL;
                if (cnt_q == COLS_A - ADDR_W'(1)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end

            StClrAll: begin
                wr_en = 1'b1;
                wr_a  = cnt_q;
                wr_do = FILL;
                if (cnt_q == TOTAL_WORDS - ADDR_W'(1)) begin
                    state_d = StIdle;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // State and cursor registers with synchronous reset
    always_ff @(posedge clk_pxl) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
        end
    end

    // Reset masks the strobes in the same cycle so an abort never writes again
    always_comb begin
        ch_ready   = (state_q == StIdle) && !rst;
        wr_ram_en  = wr_en && !rst;
        wr_ram_a   = wr_a;
        wr_ram_do  = wr_do;
        rd_ram_a   = rst ? '0 : rd_a;
        cursor_col = col_q;
        cursor_row = row_q;
        busy       = (state_q != StIdle);
    end

endmodule

// File: tb/tb_vram_console_writer.sv
// Directed bench for vram_console_writer with a behavioural video RAM.
module tb_vram_console_writer;

    logic        clk;
    logic        rst;
    logic        ch_valid;
    logic [7:0]  ch_data;
    logic        ch_ready;
    logic        wr_ram_en;
    logic [10:0] wr_ram_a;
    logic [7:0]  wr_ram_do;
    logic [10:0] rd_ram_a;
    logic [7:0]  rd_ram_di;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [2048];
    int         wr_cnt = 0;
    int         oob_cnt = 0;
    logic       preload_req = 1'b0;
    logic       preload_ack = 1'b0;
    int         preload_kind = 0;

    vram_console_writer #(
        .COLS (80),
        .ROWS (25),
        .FILL (8'h20)
    ) dut (
        .clk_pxl    (clk),
        .rst        (rst),
        .ch_valid   (ch_valid),
        .ch_data    (ch_data),
        .ch_ready   (ch_ready),
        .wr_ram_en  (wr_ram_en),
        .wr_ram_a   (wr_ram_a),
        .wr_ram_do  (wr_ram_do),
        .rd_ram_a   (rd_ram_a),
        .rd_ram_di  (rd_ram_di),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Video RAM model: one-cycle read latency, write counting, bulk preload
    always @(posedge clk) begin
        if (preload_req != preload_ack) begin
            for (int a = 0; a < 2048; a++) begin
                mem[a] <= (preload_kind == 1) ? 8'(a) : 8'hA5;
            end
            preload_ack <= preload_req;
        end else if (wr_ram_en) begin
            mem[wr_ram_a] <= wr_ram_do;
            wr_cnt <= wr_cnt + 1;
            if (wr_ram_a >= 11'd2000) oob_cnt <= oob_cnt + 1;
        end
        rd_ram_di <= mem[rd_ram_a];
    end

    task automatic preload(input int kind);
        preload_kind = kind;
        preload_req  = ~preload_req;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        ch_valid = 1'b1;
        ch_data  = b;
        while (!ch_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++; errors++;
            $display("FAIL send_timeout byte=%0h", b);
        end
        @(posedge clk);
        #1;
        ch_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL idle_timeout busy still high");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ch_valid = 1'b0;
        ch_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ch_ready !== 1'b0 || wr_ram_en !== 1'b0 || rd_ram_a !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b en=%b rda=%0d want 0 0 0",
                     ch_ready, wr_ram_en, rd_ram_a);
        end
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 7'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_cursor got r=%0d c=%0d busy=%b want 0 0 0",
                     cursor_row, cursor_col, busy);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ch_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after got %b want 1", ch_ready);
        end
    endtask

    task automatic test_put();
        int base;
        base = wr_cnt;
        @(negedge clk);
        ch_valid = 1'b1;
        ch_data  = 8'h41;
        @(posedge clk);
        #1;
        ch_valid = 1'b0;
        checks++;
        if (ch_ready !== 1'b0 || wr_ram_en !== 1'b1 || wr_ram_a !== 11'd0 ||
            wr_ram_do !== 8'h41) begin
            errors++;
            $display("FAIL put_cycle got rdy=%b en=%b a=%0d d=%0h want 0 1 0 41",
                     ch_ready, wr_ram_en, wr_ram_a, wr_ram_do);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ch_ready !== 1'b1 || wr_ram_en !== 1'b0) begin
            errors++;
            $display("FAIL put_ready_back got rdy=%b en=%b want 1 0", ch_ready, wr_ram_en);
        end
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 7'd1 || wr_cnt - base !== 1 ||
            mem[0] !== 8'h41) begin
            errors++;
            $display("FAIL put_cursor got r=%0d c=%0d writes=%0d mem0=%0h want 0 1 1 41",
                     cursor_row, cursor_col, wr_cnt - base, mem[0]);
        end
    endtask

    task automatic test_ctrl();
        int base;
        base = wr_cnt;
        send(8'h0D);
        checks++;
        if (cursor_col !== 7'd0 || ch_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cr_first got c=%0d rdy=%b busy=%b want 0 1 0",
                     cursor_col, ch_ready, busy);
        end
        send(8'h08);
        checks++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd0 || wr_cnt != base) begin
            errors++;
            $display("FAIL bs_col0 got r=%0d c=%0d writes=%0d want 0 0 0",
                     cursor_row, cursor_col, wr_cnt - base);
        end
        for (int i = 0; i < 5; i++) begin
            send(8'h61 + 8'(i));
            wait_idle();
        end
        send(8'h08);
        checks++;
        if (cursor_col !== 7'd4 || wr_cnt - base !== 5) begin
            errors++;
            $display("FAIL bs_col5 got c=%0d writes=%0d want 4 5", cursor_col, wr_cnt - base);
        end
        send(8'h0D);
        checks++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
            errors++;
            $display("FAIL cr_second got r=%0d c=%0d want 0 0", cursor_row, cursor_col);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) send(8'h0A);
        checks++;
        if (cursor_row !== 5'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL lf_rows got r=%0d busy=%b want 3 0", cursor_row, busy);
        end
        for (int i = 0; i < 79; i++) begin
            send(8'h2E);
            wait_idle();
        end
        checks++;
        if (cursor_col !== 7'd79) begin
            errors++;
            $display("FAIL wrap_setup got c=%0d want 79", cursor_col);
        end
        send(8'h42);
        checks++;
        if (wr_ram_en !== 1'b1 || wr_ram_a !== 11'd319 || wr_ram_do !== 8'h42) begin
            errors++;
            $display("FAIL wrap_put got en=%b a=%0d d=%0h want 1 319 42",
                     wr_ram_en, wr_ram_a, wr_ram_do);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cursor_row !== 5'd4 || cursor_col !== 7'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_cursor got r=%0d c=%0d busy=%b want 4 0 0",
                     cursor_row, cursor_col, busy);
        end
    endtask

    task automatic test_scroll();
        int base;
        int n;
        int bad;
        int first_bad;
        for (int i = 0; i < 20; i++) send(8'h0A);
        checks++;
        if (cursor_row !== 5'd24) begin
            errors++;
            $display("FAIL scroll_setup got r=%0d want 24", cursor_row);
        end
        preload(1);
        base = wr_cnt;
        send(8'h0A);
        checks++;
        if (wr_ram_en !== 1'b0 || rd_ram_a !== 11'd80 || busy !== 1'b1) begin
            errors++;
            $display("FAIL scroll_fill got en=%b rda=%0d busy=%b want 0 80 1",
                     wr_ram_en, rd_ram_a, busy);
        end
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (n != 2001 || wr_cnt - base != 2000) begin
            errors++;
            $display("FAIL scroll_len got busy=%0d writes=%0d want 2001 2000",
                     n, wr_cnt - base);
        end
        bad = 0;
        first_bad = -1;
        for (int p = 0; p < 2000; p++) begin
            if (mem[p] !== ((p < 1920) ? 8'(p + 80) : 8'h20)) begin
                bad++;
                if (first_bad < 0) first_bad = p;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL scroll_data got %0d bad words first at %0d want 0", bad, first_bad);
        end
        checks++;
        if (cursor_row !== 5'd24 || cursor_col !== 7'd0 || rd_ram_a !== 11'd0 ||
            oob_cnt != 0) begin
            errors++;
            $display("FAIL scroll_after got r=%0d c=%0d rda=%0d oob=%0d want 24 0 0 0",
                     cursor_row, cursor_col, rd_ram_a, oob_cnt);
        end
    endtask

    task automatic test_clear_all();
        int base;
        int n;
        int bad;
        int early;
        preload(2);
        base = wr_cnt;
        send(8'h0C);
        ch_valid = 1'b1;
        ch_data  = 8'h58;
        n = 0;
        early = 0;
        while (busy && n < 5000) begin
            if (ch_ready) early++;
            n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (n != 2000 || wr_cnt - base != 2000 || early != 0) begin
            errors++;
            $display("FAIL clr_len got busy=%0d writes=%0d early_ready=%0d want 2000 2000 0",
                     n, wr_cnt - base, early);
        end
        bad = 0;
        for (int p = 0; p < 2000; p++) if (mem[p] !== 8'h20) bad++;
        checks++;
        if (bad != 0 || cursor_row !== 5'd0 || cursor_col !== 7'd0 || ch_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_done got bad=%0d r=%0d c=%0d rdy=%b want 0 0 0 1",
                     bad, cursor_row, cursor_col, ch_ready);
        end
        @(posedge clk);
        #1;
        ch_valid = 1'b0;
        checks++;
        if (wr_ram_en !== 1'b1 || wr_ram_a !== 11'd0 || wr_ram_do !== 8'h58) begin
            errors++;
            $display("FAIL clr_held_byte got en=%b a=%0d d=%0h want 1 0 58",
                     wr_ram_en, wr_ram_a, wr_ram_do);
        end
        wait_idle();
        checks++;
        if (cursor_col !== 7'd1 || cursor_row !== 5'd0) begin
            errors++;
            $display("FAIL clr_held_cursor got r=%0d c=%0d want 0 1", cursor_row, cursor_col);
        end
    endtask

    task automatic test_reset_abort();
        int base;
        for (int i = 0; i < 24; i++) send(8'h0A);
        send(8'h0A);
        repeat (500) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || wr_ram_en !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup got busy=%b en=%b want 1 1", busy, wr_ram_en);
        end
        rst = 1'b1;
        base = wr_cnt;
        @(posedge clk);
        #1;
        checks++;
        if (wr_ram_en !== 1'b0 || busy !== 1'b0 || ch_ready !== 1'b0 || rd_ram_a !== 11'd0) begin
            errors++;
            $display("FAIL abort_outputs got en=%b busy=%b rdy=%b rda=%0d want 0 0 0 0",
                     wr_ram_en, busy, ch_ready, rd_ram_a);
        end
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
            errors++;
            $display("FAIL abort_cursor got r=%0d c=%0d want 0 0", cursor_row, cursor_col);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (wr_cnt != base) begin
            errors++;
            $display("FAIL abort_writes got %0d extra want 0", wr_cnt - base);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ch_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready got rdy=%b busy=%b want 1 0", ch_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_put();
        test_ctrl();
        test_wrap();
        test_scroll();
        test_clear_all();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
